// File: rtl/dbg_disp_pkg.sv
// Shared constants, character helpers and FSM state type for the debug text-line writer.
package dbg_disp_pkg;

  localparam int CHAR_W   = 16;
  localparam int CH_CHARS = 14;

  localparam logic [7:0]        CHAR_PREFIX = 8'hFF;
  localparam logic [CHAR_W-1:0] CHAR_COLON  = {CHAR_PREFIX, 8'h3A};
  localparam logic [CHAR_W-1:0] CHAR_SPACE  = {CHAR_PREFIX, 8'h20};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Every character cell is the ASCII byte tagged with the display attribute prefix.
  function automatic logic [CHAR_W-1:0] make_char(input logic [7:0] ascii);
    return {CHAR_PREFIX, ascii};
  endfunction

endpackage

// File: rtl/hex_char.sv
// Combinational nibble to uppercase hex character-code converter.
module hex_char
  import dbg_disp_pkg::*;
(
  input  logic [3:0]        nibble_i,
  output logic [CHAR_W-1:0] char_o
);

  logic [7:0] ascii;

  always_comb begin
    if (nibble_i < 4'd10) begin
      ascii = 8'h30 + {4'h0, nibble_i};
    end else begin
      ascii = 8'h37 + {4'h0, nibble_i};
    end
    char_o = make_char(ascii);
  end

endmodule

// File: rtl/dbg_line_writer.sv
// Writes one text line "LBL:XXXXXXXX " per channel into a character sink on each start request.
// Optional build macro DBG_CHANGE_ONLY_EN: skip channels whose value did not change since last written.
module dbg_line_writer
  import dbg_disp_pkg::*;
#(
  parameter int                     NUM_CH     = 2,
  parameter int                     BASE_ADDR  = 68,
  parameter int                     ADDR_W     = 8,
  parameter logic [NUM_CH-1:0]      SHIFT_MASK = NUM_CH'(1),
  // Channel 0 ("INS ") sits in the low word, so it is the first label on the line.
  parameter logic [NUM_CH*32-1:0]   LABELS     = {"PC  ", "INS "}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  word_mode,
  input  logic [NUM_CH*32-1:0]  data_in,
  input  logic                  wr_ready,
  output logic                  wr_valid,
  output logic [ADDR_W-1:0]     wr_addr,
  output logic [CHAR_W-1:0]     wr_data,
  output logic                  busy,
  output logic                  done
);

  localparam int DW   = NUM_CH * 32;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  state_e          state_q, state_d;
  logic [DW-1:0]   snap_q, snap_d;
  logic            mode_q, mode_d;
  logic [CH_W-1:0] ch_q, ch_d;
  logic [3:0]      char_q, char_d;

  logic [DW-1:0]     shifted;
  logic [31:0]       cur_val;
  logic [3:0]        nibble;
  logic [CHAR_W-1:0] hex_code;
  logic [CHAR_W-1:0] char_code;
  logic [ADDR_W-1:0] char_addr;
  int                ch_idx;
  int                k_idx;
  logic              ch_active;
  logic              emit_write;
  logic              write_fire;
  logic              last_ch;
  logic              last_char;
  logic              ch_done;

  function automatic logic [DW-1:0] apply_shift(input logic [DW-1:0] d, input logic m);
    logic [DW-1:0] r;
    for (int i = 0; i < NUM_CH; i++) begin
      r[i*32 +: 32] = (m && SHIFT_MASK[i]) ? {2'b00, d[i*32+2 +: 30]} : d[i*32 +: 32];
    end
    return r;
  endfunction

`ifdef DBG_CHANGE_ONLY_EN
  logic [DW-1:0]     hist_q, hist_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [DW-1:0]     in_shifted;

  assign in_shifted = apply_shift(data_in, word_mode);
  assign ch_active  = mask_q[ch_q];
`else
  assign ch_active  = 1'b1;
`endif

  assign shifted    = apply_shift(snap_q, mode_q);
  assign ch_idx     = int'(ch_q);
  assign k_idx      = int'(char_q);
  assign cur_val    = shifted[ch_idx*32 +: 32];
  assign last_ch    = (ch_q == CH_W'(NUM_CH - 1));
  assign last_char  = (char_q == 4'(CH_CHARS - 1));
  assign emit_write = (state_q == ST_EMIT) && ch_active;
  assign write_fire = emit_write && wr_ready;
  assign ch_done    = !ch_active || (write_fire && last_char);

  // Address arithmetic is done at ADDR_W width so it wraps modulo 2^ADDR_W.
  assign char_addr = ADDR_W'(BASE_ADDR) + ADDR_W'(CH_CHARS) * ADDR_W'(ch_q) + ADDR_W'(char_q);

  always_comb begin
    nibble = cur_val[31:28];
    if (k_idx >= 5 && k_idx <= 12) begin
      nibble = cur_val[(12-k_idx)*4 +: 4];
    end
  end

  hex_char u_hex_char (
    .nibble_i (nibble),
    .char_o   (hex_code)
  );

  // Field layout: 4 label characters, colon, 8 hex digits MS nibble first, space.
  always_comb begin
    char_code = CHAR_SPACE;
    if (k_idx < 4) begin
      char_code = make_char(LABELS[ch_idx*32 + (3-k_idx)*8 +: 8]);
    end else if (k_idx == 4) begin
      char_code = CHAR_COLON;
    end else if (k_idx <= 12) begin
      char_code = hex_code;
    end
  end

  assign wr_valid = emit_write;
  assign wr_addr  = emit_write ? char_addr : '0;
  assign wr_data  = emit_write ? char_code : '0;
  assign busy     = (state_q != ST_IDLE);
  assign done     = (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    mode_d  = mode_q;
    ch_d    = ch_q;
    char_d  = char_q;
`ifdef DBG_CHANGE_ONLY_EN
    hist_d  = hist_q;
    mask_d  = mask_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_EMIT;
          snap_d  = data_in;
          mode_d  = word_mode;
          ch_d    = '0;
          char_d  = '0;
`ifdef DBG_CHANGE_ONLY_EN
          for (int i = 0; i < NUM_CH; i++) begin
            mask_d[i] = (in_shifted[i*32 +: 32] != hist_q[i*32 +: 32]);
          end
`endif
        end
      end
      ST_EMIT: begin
`ifdef DBG_CHANGE_ONLY_EN
        if (write_fire && last_char) begin
          hist_d[ch_idx*32 +: 32] = cur_val;
        end
`endif
        if (ch_done) begin
          char_d = '0;
          if (last_ch) begin
            state_d = ST_DONE;
          end else begin
            ch_d = ch_q + CH_W'(1);
          end
        end else if (write_fire) begin
          char_d = char_q + 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      snap_q  <= '0;
      mode_q  <= 1'b0;
      ch_q    <= '0;
      char_q  <= '0;
`ifdef DBG_CHANGE_ONLY_EN
      hist_q  <= '0;
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      mode_q  <= mode_d;
      ch_q    <= ch_d;
      char_q  <= char_d;
`ifdef DBG_CHANGE_ONLY_EN
      hist_q  <= hist_d;
      mask_q  <= mask_d;
`endif
    end
  end

endmodule

// File: tb/tb_dbg_line_writer.sv
// Scoreboard testbench for dbg_line_writer: expected characters are queued per line and popped on each write handshake.
module tb_dbg_line_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        word_mode;
  logic [63:0] data_in;
  logic        wr_ready;
  logic        wr_valid;
  logic [7:0]  wr_addr;
  logic [15:0] wr_data;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  logic [23:0] exp_q[$];
  logic [7:0]  addr_log[$];
  logic [31:0] model_hist[2];
  logic [15:0] wr_log[256];
  int          write_count = 0;
  int          done_count  = 0;
  logic        held = 1'b0;
  logic [7:0]  held_addr;
  logic [15:0] held_data;
  logic        prev_done = 1'b0;
  logic [23:0] exp_e;

  dbg_line_writer #(
    .NUM_CH     (2),
    .BASE_ADDR  (68),
    .ADDR_W     (8),
    .SHIFT_MASK (2'b01),
    .LABELS     ({"PC  ", "INS "})
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .word_mode (word_mode),
    .data_in   (data_in),
    .wr_ready  (wr_ready),
    .wr_valid  (wr_valid),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .busy      (busy),
    .done      (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required to finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    string hx = "0123456789ABCDEF";
    return hx[int'(n)];
  endfunction

  // Reference model of one line: label, colon, hex digits, space for each channel.
  task automatic push_line(input logic [31:0] c0, input logic [31:0] c1, input logic mode);
    logic [31:0] v;
    logic [7:0]  ch;
    logic [7:0]  a;
    string       lbl;
    for (int c = 0; c < 2; c++) begin
      v = (c == 0) ? c0 : c1;
      if (mode && c == 0) v = v >> 2;
`ifdef DBG_CHANGE_ONLY_EN
      if (v == model_hist[c]) continue;
`endif
      model_hist[c] = v;
      lbl = (c == 0) ? "INS " : "PC  ";
      for (int k = 0; k < 14; k++) begin
        if (k < 4)       ch = lbl[k];
        else if (k == 4) ch = 8'h3A;
        else if (k < 13) ch = hex_ascii(v[(12-k)*4 +: 4]);
        else             ch = 8'h20;
        a = 8'(68 + 14*c + k);
        exp_q.push_back({a, 8'hFF, ch});
      end
    end
  endtask

  // Monitor: handshake scoreboard, stall stability and done pulse width.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (held) begin
        checks++;
        if (wr_valid !== 1'b1 || wr_addr !== held_addr || wr_data !== held_data) begin
          errors++;
          $display("[TB] FAIL stall_hold: got valid=%b addr=%0d data=%h, required valid=1 addr=%0d data=%h",
                   wr_valid, wr_addr, wr_data, held_addr, held_data);
        end
      end
      if (wr_valid === 1'b1 && wr_ready === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("[TB] FAIL unexpected_write: got addr=%0d data=%h, required no write", wr_addr, wr_data);
        end else begin
          exp_e = exp_q.pop_front();
          if ({wr_addr, wr_data} !== exp_e) begin
            errors++;
            $display("[TB] FAIL write_char: got addr=%0d data=%h, required addr=%0d data=%h",
                     wr_addr, wr_data, exp_e[23:16], exp_e[15:0]);
          end
        end
        wr_log[wr_addr] = wr_data;
        addr_log.push_back(wr_addr);
        write_count++;
      end
      held      = (wr_valid === 1'b1) && (wr_ready !== 1'b1);
      held_addr = wr_addr;
      held_data = wr_data;
      if (done === 1'b1) begin
        done_count++;
        checks++;
        if (prev_done) begin
          errors++;
          $display("[TB] FAIL done_width: got done high for 2+ cycles, required 1");
        end
      end
      prev_done = (done === 1'b1);
    end else begin
      held      = 1'b0;
      prev_done = 1'b0;
    end
  end

  task automatic wait_line(input bit toggle, input int pulse_at, output int cycles, output int first_valid);
    bit seen;
    seen        = 1'b0;
    cycles      = 0;
    first_valid = -1;
    while (!seen && cycles < 400) begin
      @(negedge clk);
      cycles++;
      if (wr_valid === 1'b1 && first_valid < 0) first_valid = cycles;
      if (done === 1'b1) begin
        seen = 1'b1;
      end else if (toggle || pulse_at > 0) begin
        @(posedge clk);
        #1;
        if (toggle) wr_ready = ~wr_ready;
        start = (cycles == pulse_at);
      end
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("[TB] FAIL line_timeout: got no done after %0d cycles, required done", cycles);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
  endtask

  task automatic run_line(input logic [31:0] c0, input logic [31:0] c1, input logic mode,
                          input bit toggle, input int pulse_at,
                          output int cycles, output int first_valid, output int nwrites);
    int wc0;
    int dc0;
    int exp_n;
    exp_q.delete();
    push_line(c0, c1, mode);
    exp_n     = exp_q.size();
    wc0       = write_count;
    dc0       = done_count;
    data_in   = {c1, c0};
    word_mode = mode;
    start     = 1'b1;
    @(negedge clk);
    checks++;
    if (wr_valid !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL pre_accept: got valid=%b busy=%b, required 0 0", wr_valid, busy);
    end
    @(posedge clk);
    #1;
    start     = 1'b0;
    data_in   = ~data_in;
    word_mode = ~mode;
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("[TB] FAIL busy_after_accept: got %b, required 1", busy);
    end
    wait_line(toggle, pulse_at, cycles, first_valid);
    nwrites = write_count - wc0;
    checks++;
    if (nwrites != exp_n) begin
      errors++;
      $display("[TB] FAIL line_writes: got %0d, required %0d", nwrites, exp_n);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL leftover: got %0d pending characters, required 0", exp_q.size());
    end
    checks++;
    if (done_count - dc0 != 1) begin
      errors++;
      $display("[TB] FAIL done_pulses: got %0d, required 1", done_count - dc0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL busy_after_done: got %b, required 0", busy);
    end
  endtask

  task automatic check_digits(input string name, input int base, input string s);
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wr_log[base+i] !== {8'hFF, s[i]}) begin
        errors++;
        $display("[TB] FAIL %s: addr %0d got %h, required %h", name, base+i, wr_log[base+i], {8'hFF, s[i]});
      end
    end
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    start     = 1'b0;
    word_mode = 1'b0;
    data_in   = '0;
    wr_ready  = 1'b1;
    model_hist[0] = '0;
    model_hist[1] = '0;
    #1;
    checks++;
    if ({wr_valid, wr_addr, wr_data, busy, done} !== 27'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got valid=%b addr=%0d data=%h busy=%b done=%b, required all 0",
               wr_valid, wr_addr, wr_data, busy, done);
    end
    start = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || wr_valid !== 1'b0) begin
      errors++;
      $display("[TB] FAIL reset_holds_idle: got busy=%b valid=%b, required 0 0", busy, wr_valid);
    end
    start = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (busy !== 1'b0 || wr_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("[TB] FAIL idle_after_reset: got busy=%b valid=%b done=%b, required 0 0 0", busy, wr_valid, done);
    end
  endtask

  task automatic test_shift_mode();
    int cyc, fv, nw;
    run_line(32'h00400010, 32'h0000CAFE, 1'b1, 1'b0, 0, cyc, fv, nw);
    checks++;
    if (fv != 1) begin
      errors++;
      $display("[TB] FAIL first_valid_cycle: got %0d, required 1", fv);
    end
    checks++;
    if (cyc != 29) begin
      errors++;
      $display("[TB] FAIL line_cycles: got %0d, required 29", cyc);
    end
    checks++;
    if (wr_log[68] !== 16'hFF49 || wr_log[72] !== 16'hFF3A || wr_log[81] !== 16'hFF20) begin
      errors++;
      $display("[TB] FAIL field_chars: got %h %h %h, required ff49 ff3a ff20", wr_log[68], wr_log[72], wr_log[81]);
    end
    check_digits("shift_digits", 73, "00100004");
  endtask

  task automatic test_no_shift();
    int cyc, fv, nw;
    run_line(32'h00400010, 32'h0000CAFE, 1'b0, 1'b0, 0, cyc, fv, nw);
    check_digits("noshift_digits", 73, "00400010");
  endtask

  task automatic test_stall();
    int cyc, fv, nw;
    logic [15:0] dead[8];
    dead = '{16'hFF44, 16'hFF45, 16'hFF41, 16'hFF44, 16'hFF42, 16'hFF45, 16'hFF45, 16'hFF46};
    wr_ready = 1'b1;
    run_line(32'h12345678, 32'hDEADBEEF, 1'b1, 1'b1, 0, cyc, fv, nw);
    wr_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (wr_log[87+i] !== dead[i]) begin
        errors++;
        $display("[TB] FAIL stall_digits: addr %0d got %h, required %h", 87+i, wr_log[87+i], dead[i]);
      end
    end
  endtask

  task automatic test_busy_start();
    int cyc, fv, nw, wc;
    run_line(32'hA5A50001, 32'h0F0FF0F0, 1'b0, 1'b0, 6, cyc, fv, nw);
    wc = write_count;
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (write_count != wc || busy !== 1'b0) begin
      errors++;
      $display("[TB] FAIL start_ignored: got %0d extra writes busy=%b, required 0 writes busy=0", write_count - wc, busy);
    end
  endtask

  task automatic test_reset_mid_line();
    int cyc, fv, nw, wc0, n;
    exp_q.delete();
    push_line(32'h00000123, 32'h00000456, 1'b0);
    wc0       = write_count;
    data_in   = {32'h00000456, 32'h00000123};
    word_mode = 1'b0;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (write_count < wc0 + 10 && n < 100) begin
      @(posedge clk);
      n++;
    end
    #1;
    checks++;
    if (write_count < wc0 + 10) begin
      errors++;
      $display("[TB] FAIL reset_wait: got %0d writes, required 10", write_count - wc0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wr_valid, wr_addr, wr_data, busy, done} !== 27'd0) begin
      errors++;
      $display("[TB] FAIL reset_mid_outputs: got valid=%b addr=%0d data=%h busy=%b done=%b, required all 0",
               wr_valid, wr_addr, wr_data, busy, done);
    end
    exp_q.delete();
    model_hist[0] = '0;
    model_hist[1] = '0;
    wc0 = write_count;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (write_count != wc0) begin
      errors++;
      $display("[TB] FAIL write_in_reset: got %0d writes, required 0", write_count - wc0);
    end
    run_line(32'h00000123, 32'h00000456, 1'b0, 1'b0, 0, cyc, fv, nw);
    checks++;
    if (nw != 28 || addr_log[wc0] !== 8'd68) begin
      errors++;
      $display("[TB] FAIL restart_line: got %0d writes from addr %0d, required 28 from 68", nw, addr_log[wc0]);
    end
  endtask

  task automatic test_back_to_back();
    int cyc, fv, nw, wc0, exp_n, exp_a;
`ifdef DBG_CHANGE_ONLY_EN
    exp_n = 14;
    exp_a = 82;
`else
    exp_n = 28;
    exp_a = 68;
`endif
    run_line(32'h11112222, 32'h33334444, 1'b0, 1'b0, 0, cyc, fv, nw);
    wc0 = write_count;
    run_line(32'h11112222, 32'h55556666, 1'b0, 1'b0, 0, cyc, fv, nw);
    checks++;
    if (nw != exp_n || int'(addr_log[wc0]) != exp_a) begin
      errors++;
      $display("[TB] FAIL second_line: got %0d writes from addr %0d, required %0d from %0d",
               nw, addr_log[wc0], exp_n, exp_a);
    end
  endtask

  initial begin
    test_reset();
    test_shift_mode();
    test_no_shift();
    test_stall();
    test_busy_start();
    test_reset_mid_line();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
